// File: rtl/pipe_barrel_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter, one binary-weighted stage per shamt bit, tag carried alongside.
// Latency 1 + popcount(PIPE_MASK[LOG2W-2:0]); valid/ready with combinational ready chain, bubbles collapse.
// Define SHIFTER_WIDE_SHAMT_EN for a LOG2W+1 bit shift amount with saturation of amounts >= WIDTH.
module pipe_barrel_shifter #(
    parameter int               WIDTH     = 32,
    parameter int               LOG2W     = $clog2(WIDTH),
    parameter logic [LOG2W-1:0] PIPE_MASK = 'b00100,
    parameter int               TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef SHIFTER_WIDE_SHAMT_EN
    input  logic [LOG2W:0]   in_shamt,
`else
    input  logic [LOG2W-1:0] in_shamt,
`endif
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_z,
    output logic             out_n
);

`ifdef SHIFTER_WIDE_SHAMT_EN
    localparam int SW = LOG2W + 1;
`else
    localparam int SW = LOG2W;
`endif

    // The slot after the last stage is the output register and always exists.
    localparam logic [LOG2W-1:0] IS_REG = PIPE_MASK | LOG2W'(1 << (LOG2W - 1));

    // ent_*[k] is what stage k sees at its input; st_dat[k] is its shifted result.
    logic [LOG2W-1:0] ent_vld;
    logic [WIDTH-1:0] ent_dat   [LOG2W];
    logic [SW-1:0]    ent_shamt [LOG2W];
    logic [1:0]       ent_op    [LOG2W];
    logic             ent_sign  [LOG2W];
    logic [TAG_W-1:0] ent_tag   [LOG2W];
    logic [WIDTH-1:0] st_dat    [LOG2W];
    logic [LOG2W:0]   rdy;

    // Slot state; entries whose IS_REG bit is clear are never loaded.
    logic [LOG2W-1:0] vld_q;
    logic [WIDTH-1:0] dat_q   [LOG2W];
    logic [SW-1:0]    shamt_q [LOG2W];
    logic [1:0]       op_q    [LOG2W];
    logic             sign_q  [LOG2W];
    logic [TAG_W-1:0] tag_q   [LOG2W];
    logic             z_q;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input logic sign,
                                                  input logic [1:0] op, input int amt);
        logic [WIDTH-1:0] fill;
        fill = ~({WIDTH{1'b1}} >> amt);
        case (op)
            2'b00:   shift_by = d << amt;
            2'b01:   shift_by = d >> amt;
            2'b10:   shift_by = (d >> amt) | (sign ? fill : '0);
            default: shift_by = (d >> amt) | (d << (WIDTH - amt));
        endcase
    endfunction

    always_comb begin
        ent_vld = '0;
        rdy     = '0;
        for (int k = 0; k < LOG2W; k++) begin
            ent_dat[k]   = '0;
            ent_shamt[k] = '0;
            ent_op[k]    = '0;
            ent_sign[k]  = 1'b0;
            ent_tag[k]   = '0;
            st_dat[k]    = '0;
        end
        ent_vld[0]   = in_valid;
        ent_dat[0]   = in_data;
        ent_shamt[0] = in_shamt;
        ent_op[0]    = in_op;
        ent_sign[0]  = in_data[WIDTH-1];
        ent_tag[0]   = in_tag;
        for (int k = 0; k < LOG2W; k++) begin
            st_dat[k] = ent_shamt[k][k] ? shift_by(ent_dat[k], ent_sign[k], ent_op[k], 1 << k)
                                        : ent_dat[k];
            if (k < LOG2W - 1) begin
                ent_vld[k+1]   = IS_REG[k] ? vld_q[k]   : ent_vld[k];
                ent_dat[k+1]   = IS_REG[k] ? dat_q[k]   : st_dat[k];
                ent_shamt[k+1] = IS_REG[k] ? shamt_q[k] : ent_shamt[k];
                ent_op[k+1]    = IS_REG[k] ? op_q[k]    : ent_op[k];
                ent_sign[k+1]  = IS_REG[k] ? sign_q[k]  : ent_sign[k];
                ent_tag[k+1]   = IS_REG[k] ? tag_q[k]   : ent_tag[k];
            end
        end
`ifdef SHIFTER_WIDE_SHAMT_EN
        // The shamt MSB rode down the pipe as the saturate flag; ROR keeps the mod-WIDTH rotate.
        if (ent_shamt[LOG2W-1][LOG2W] && ent_op[LOG2W-1] != 2'b11)
            st_dat[LOG2W-1] = (ent_op[LOG2W-1] == 2'b10) ? {WIDTH{ent_sign[LOG2W-1]}} : '0;
`endif
        rdy[LOG2W] = out_ready;
        for (int k = LOG2W - 1; k >= 0; k--)
            rdy[k] = IS_REG[k] ? (!vld_q[k] || rdy[k+1]) : rdy[k+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            z_q   <= 1'b0;
            for (int k = 0; k < LOG2W; k++) begin
                dat_q[k]   <= '0;
                shamt_q[k] <= '0;
                op_q[k]    <= '0;
                sign_q[k]  <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < LOG2W; k++) begin
                if (IS_REG[k] && rdy[k]) begin
                    vld_q[k] <= ent_vld[k];
                    if (ent_vld[k]) begin
                        dat_q[k]   <= st_dat[k];
                        shamt_q[k] <= ent_shamt[k];
                        op_q[k]    <= ent_op[k];
                        sign_q[k]  <= ent_sign[k];
                        tag_q[k]   <= ent_tag[k];
                    end
                end
            end
            if (rdy[LOG2W-1] && ent_vld[LOG2W-1])
                z_q <= (st_dat[LOG2W-1] == '0);
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[LOG2W-1];
    assign out_data  = dat_q[LOG2W-1];
    assign out_tag   = tag_q[LOG2W-1];
    assign out_z     = z_q;
    assign out_n     = dat_q[LOG2W-1][WIDTH-1];

endmodule
